iqft3_sequential: RTL

Iterative 3-qubit inverse QFT engine. It accepts an 8-amplitude complex state vector over a valid/ready handshake and applies the bit-reversal SWAP followed by the conjugated QFT gate sequence in reverse order. Gates are applied in place to an 8-entry register file, one amplitude pair per cycle, through a single shared H/complex-multiply datapath. It sits downstream of the pipelined forward QFT and maps a transformed vector back to the computational basis. It trades throughput for about one quarter of the forward pipeline's arithmetic area.

---
 rtl/iqft3_sequential.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/iqft3_sequential.sv
// ---------------------------------------------------------------------------
// iqft3_sequential
//
// Iterative 3-qubit inverse QFT engine. A loaded 8-amplitude complex vector
// is transformed in place inside an 8-entry register file: first the
// bit-reversal SWAP, then the conjugated QFT gates in reverse order
// (H q0, CROT -pi/2, H q1, CROT -pi/4, CROT -pi/2, H q2). One micro-op is
// executed per cycle through a single shared Hadamard / complex-multiply
// datapath, so a vector takes 19 cycles of RUN.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   input vector valid
//   in_ready   engine idle, a vector is accepted when in_valid is high
//   in_re/in_im   8 packed amplitudes, amplitude k at [k*WIDTH +: WIDTH]
//   out_valid  result vector is held on out_re/out_im
//   out_ready  consumer takes the result
//   out_re/out_im 8 packed result amplitudes, straight from the register file
//   busy       high while micro-ops are executing
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

// The project fixed-point header normally supplies the amplitude width;
// fall back to 16 bits when that header has not been included.
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 16
`endif

module iqft3_sequential #(
   parameter int WIDTH     = `TOTAL_WIDTH,
   parameter int FRAC_BITS = 4,
   parameter int INV_SQRT2 = 11
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [8*WIDTH-1:0]   in_re,
   input  logic [8*WIDTH-1:0]   in_im,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [8*WIDTH-1:0]   out_re,
   output logic [8*WIDTH-1:0]   out_im,
   output logic                 busy
);

   localparam int SW = WIDTH + 1;
   localparam int MW = 2 * WIDTH;
   localparam int PW = 2 * WIDTH + 1;
   localparam logic [4:0] LAST_STEP = 5'd18;

   localparam logic signed [WIDTH-1:0] INV_K     = WIDTH'(INV_SQRT2);
   localparam logic signed [WIDTH-1:0] NEG_INV_K = WIDTH'(-INV_SQRT2);
   localparam logic signed [WIDTH-1:0] NEG_ONE_K = WIDTH'(-(1 << FRAC_BITS));

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   typedef enum logic [1:0] {OP_SWAP, OP_H, OP_CROT} op_t;

   state_t state, next_state;
   logic [4:0] step;

   logic signed [WIDTH-1:0] rf_re [8];
   logic signed [WIDTH-1:0] rf_im [8];

   op_t op;
   logic [2:0] idx_a, idx_b;
   logic signed [WIDTH-1:0] mul_re, mul_im;

   logic signed [WIDTH-1:0] a_re, a_im, b_re, b_im;
   logic signed [SW-1:0] sum_re, dif_re, sum_im, dif_im;
   logic signed [PW-1:0] p_sum_re, p_dif_re, p_sum_im, p_dif_im;
   logic signed [WIDTH-1:0] h_a_re, h_b_re, h_a_im, h_b_im;
   logic signed [MW-1:0] p_rr, p_ii, p_ri, p_ir;
   logic signed [MW:0] cm_sum_re, cm_sum_im;
   logic signed [WIDTH-1:0] cm_re, cm_im;

   // Micro-op schedule: maps the step counter to the operation, the entries
   // it touches and, for controlled rotations, the complex multiplier.
   // Unlisted CROT steps use the -pi/2 multiplier (0, -1.0) by default.
   always_comb begin
      op     = OP_H;
      idx_a  = 3'd0;
      idx_b  = 3'd0;
      mul_re = '0;
      mul_im = NEG_ONE_K;
      case (step)
         5'd0:  op = OP_SWAP;
         5'd1:  begin idx_a = 3'd0; idx_b = 3'd1; end
         5'd2:  begin idx_a = 3'd2; idx_b = 3'd3; end
         5'd3:  begin idx_a = 3'd4; idx_b = 3'd5; end
         5'd4:  begin idx_a = 3'd6; idx_b = 3'd7; end
         5'd5:  begin op = OP_CROT; idx_a = 3'd3; end
         5'd6:  begin op = OP_CROT; idx_a = 3'd7; end
         5'd7:  begin idx_a = 3'd0; idx_b = 3'd2; end
         5'd8:  begin idx_a = 3'd1; idx_b = 3'd3; end
         5'd9:  begin idx_a = 3'd4; idx_b = 3'd6; end
         5'd10: begin idx_a = 3'd5; idx_b = 3'd7; end
         5'd11: begin op = OP_CROT; idx_a = 3'd5; mul_re = INV_K; mul_im = NEG_INV_K; end
         5'd12: begin op = OP_CROT; idx_a = 3'd7; mul_re = INV_K; mul_im = NEG_INV_K; end
         5'd13: begin op = OP_CROT; idx_a = 3'd6; end
         5'd14: begin op = OP_CROT; idx_a = 3'd7; end
         5'd15: begin idx_a = 3'd0; idx_b = 3'd4; end
         5'd16: begin idx_a = 3'd1; idx_b = 3'd5; end
         5'd17: begin idx_a = 3'd2; idx_b = 3'd6; end
         5'd18: begin idx_a = 3'd3; idx_b = 3'd7; end
         default: op = OP_H;
      endcase
   end

   assign a_re = rf_re[idx_a];
   assign a_im = rf_im[idx_a];
   assign b_re = rf_re[idx_b];
   assign b_im = rf_im[idx_b];

   // Shared arithmetic. The Hadamard sum/difference is one bit wider than
   // an amplitude and is scaled by 1/sqrt2 at full product width; the
   // complex multiply keeps each product at 2*WIDTH and adds before shifting.
   // Both paths floor via arithmetic shift and then wrap to WIDTH bits.
   always_comb begin
      sum_re    = SW'(a_re) + SW'(b_re);
      dif_re    = SW'(a_re) - SW'(b_re);
      sum_im    = SW'(a_im) + SW'(b_im);
      dif_im    = SW'(a_im) - SW'(b_im);
      p_sum_re  = PW'(sum_re) * PW'(INV_K);
      p_dif_re  = PW'(dif_re) * PW'(INV_K);
      p_sum_im  = PW'(sum_im) * PW'(INV_K);
      p_dif_im  = PW'(dif_im) * PW'(INV_K);
      h_a_re    = WIDTH'(p_sum_re >>> FRAC_BITS);
      h_b_re    = WIDTH'(p_dif_re >>> FRAC_BITS);
      h_a_im    = WIDTH'(p_sum_im >>> FRAC_BITS);
      h_b_im    = WIDTH'(p_dif_im >>> FRAC_BITS);

      p_rr      = MW'(a_re) * MW'(mul_re);
      p_ii      = MW'(a_im) * MW'(mul_im);
      p_ri      = MW'(a_re) * MW'(mul_im);
      p_ir      = MW'(a_im) * MW'(mul_re);
      cm_sum_re = (MW+1)'(p_rr) - (MW+1)'(p_ii);
      cm_sum_im = (MW+1)'(p_ri) + (MW+1)'(p_ir);
      cm_re     = WIDTH'(cm_sum_re >>> FRAC_BITS);
      cm_im     = WIDTH'(cm_sum_im >>> FRAC_BITS);
   end

   // Control state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state and handshake outputs. Returning to IDLE only after the
   // output handshake keeps input and output acceptance in separate cycles.
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) next_state = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (step == LAST_STEP) next_state = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Step counter: cleared on load, advanced once per executed micro-op.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          step <= '0;
      else if (state == IDLE && in_valid) step <= '0;
      else if (state == RUN)            step <= step + 5'd1;
   end

   // Register file: parallel load in IDLE, one in-place micro-op per RUN
   // cycle, untouched in DONE so the result stays stable on the outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 8; k++) begin
            rf_re[k] <= '0;
            rf_im[k] <= '0;
         end
      end else if (state == IDLE) begin
         if (in_valid) begin
            for (int k = 0; k < 8; k++) begin
               rf_re[k] <= in_re[k*WIDTH +: WIDTH];
               rf_im[k] <= in_im[k*WIDTH +: WIDTH];
            end
         end
      end else if (state == RUN) begin
         case (op)
            OP_SWAP: begin
               rf_re[1] <= rf_re[4];
               rf_re[4] <= rf_re[1];
               rf_im[1] <= rf_im[4];
               rf_im[4] <= rf_im[1];
               rf_re[3] <= rf_re[6];
               rf_re[6] <= rf_re[3];
               rf_im[3] <= rf_im[6];
               rf_im[6] <= rf_im[3];
            end
            OP_H: begin
               rf_re[idx_a] <= h_a_re;
               rf_im[idx_a] <= h_a_im;
               rf_re[idx_b] <= h_b_re;
               rf_im[idx_b] <= h_b_im;
            end
            OP_CROT: begin
               rf_re[idx_a] <= cm_re;
               rf_im[idx_a] <= cm_im;
            end
            default: ;
         endcase
      end
   end

   for (genvar k = 0; k < 8; k++) begin : g_pack
      assign out_re[k*WIDTH +: WIDTH] = rf_re[k];
      assign out_im[k*WIDTH +: WIDTH] = rf_im[k];
   end

endmodule
